// File: rtl/mc14500_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mc14500_pkg
// Brief    : Shared MC14500B opcode encoding and sequencer FSM state type.
// Revision : 1.0
// ============================================================================
package mc14500_pkg;

    localparam int OPC_W = 4;

    typedef enum logic [OPC_W-1:0] {
        OP_NOPO = 4'h0,
        OP_LD   = 4'h1,
        OP_LDC  = 4'h2,
        OP_AND  = 4'h3,
        OP_ANDC = 4'h4,
        OP_OR   = 4'h5,
        OP_ORC  = 4'h6,
        OP_XNOR = 4'h7,
        OP_STO  = 4'h8,
        OP_STOC = 4'h9,
        OP_IEN  = 4'hA,
        OP_OEN  = 4'hB,
        OP_JMP  = 4'hC,
        OP_RTN  = 4'hD,
        OP_SKZ  = 4'hE,
        OP_NOPF = 4'hF
    } instruction_t;

    typedef enum logic [0:0] {
        RUN  = 1'b0,
        HALT = 1'b1
    } seq_state_t;

endpackage
`default_nettype wire

// File: rtl/mc14500_rstack.sv
`default_nettype none
// ============================================================================
// Module   : mc14500_rstack
// Brief    : LIFO return-address stack; illegal push/pop pulses err and is dropped.
// Revision : 1.0
// ============================================================================
module mc14500_rstack #(
    parameter int DEPTH  = 4,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic              pop,
    input  logic [DATA_W-1:0] din,
    output logic [DATA_W-1:0] dout,
    output logic              full,
    output logic              empty,
    output logic              err
);
    localparam int SP_W = $clog2(DEPTH + 1);

    logic [SP_W-1:0]   r_sp;
    logic [DATA_W-1:0] r_mem [DEPTH];

    assign full  = (r_sp == SP_W'(DEPTH));
    assign empty = (r_sp == '0);
    assign err   = (push && full) || (pop && empty);

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_sp <= '0;
        end else if (push && !full) begin
            r_sp <= r_sp + SP_W'(1);
        end else if (pop && !empty) begin
            r_sp <= r_sp - SP_W'(1);
        end
    end

    // Storage is deliberately not reset; only the pointer defines validity.
    always_ff @(posedge clk) begin
        for (int i = 0; i < DEPTH; i++) begin
            if (push && !full && (r_sp == SP_W'(i))) begin
                r_mem[i] <= din;
            end
        end
    end

    always_comb begin
        dout = r_mem[0];
        for (int i = 1; i < DEPTH; i++) begin
            if (r_sp == SP_W'(i + 1)) begin
                dout = r_mem[i];
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/mc14500_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : mc14500_sequencer
// Brief    : Program counter, ROM addressing, jump/return/halt control for the ICU.
// Revision : 1.0
// ============================================================================
module mc14500_sequencer
    import mc14500_pkg::*;
#(
    parameter int ADDR_W      = 8,
    parameter int STACK_DEPTH = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    output logic [ADDR_W-1:0]       rom_addr,
    input  logic [OPC_W+ADDR_W-1:0] rom_data,
    output logic [OPC_W-1:0]        opcode,
    input  logic                    icu_jmp,
    input  logic                    icu_rtn,
    input  logic                    icu_flag_f,
    output logic                    icu_rst,
    input  logic                    resume,
    output logic                    halted,
    output logic                    stack_err
);
    seq_state_t        r_state;
    seq_state_t        w_state_nxt;
    logic [ADDR_W-1:0] r_pc;
    logic [ADDR_W-1:0] w_pc_nxt;
    logic [ADDR_W-1:0] w_pc_inc;
    logic [ADDR_W-1:0] w_operand;
    logic [ADDR_W-1:0] w_top;
    logic              w_jmp_req;
    logic              w_push;
    logic              w_pop;
    logic              w_full;
    logic              w_empty;
    logic              w_stk_err;
    logic              r_rst_q;
    logic              r_icu_rst;
    logic              r_stack_err;

    assign w_pc_inc  = r_pc + ADDR_W'(1);
    assign w_operand = rom_data[ADDR_W-1:0];
    // Overflow is flagged here; the stack never sees a push while full.
    assign w_push    = w_jmp_req && !w_full;

    mc14500_rstack #(
        .DEPTH  (STACK_DEPTH),
        .DATA_W (ADDR_W)
    ) u_rstack (
        .clk   (clk),
        .rst   (rst),
        .push  (w_push),
        .pop   (w_pop),
        .din   (w_pc_inc),
        .dout  (w_top),
        .full  (w_full),
        .empty (w_empty),
        .err   (w_stk_err)
    );

    always_comb begin
        w_state_nxt = r_state;
        w_pc_nxt    = r_pc;
        w_jmp_req   = 1'b0;
        w_pop       = 1'b0;
        if (!r_icu_rst) begin
            case (r_state)
                RUN: begin
                    if (icu_rtn) begin
                        w_pop    = 1'b1;
                        w_pc_nxt = w_empty ? w_pc_inc : w_top;
                    end else if (icu_jmp) begin
                        w_jmp_req = 1'b1;
                        w_pc_nxt  = w_operand;
                    end else if (icu_flag_f) begin
                        w_pc_nxt    = w_pc_inc;
                        w_state_nxt = HALT;
                    end else begin
                        w_pc_nxt = w_pc_inc;
                    end
                end
                HALT: begin
                    if (resume) begin
                        w_state_nxt = RUN;
                    end
                end
                default: w_state_nxt = RUN;
            endcase
        end
    end

    // icu_rst stays high for one extra cycle after rst releases.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state     <= RUN;
            r_pc        <= '0;
            r_rst_q     <= 1'b1;
            r_icu_rst   <= 1'b1;
            r_stack_err <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_pc        <= w_pc_nxt;
            r_rst_q     <= 1'b0;
            r_icu_rst   <= r_rst_q;
            r_stack_err <= r_stack_err | w_stk_err | (w_jmp_req & w_full);
        end
    end

    assign rom_addr  = r_pc;
    assign opcode    = ((r_state == RUN) && !r_icu_rst) ? rom_data[OPC_W+ADDR_W-1:ADDR_W]
                                                        : OP_NOPO;
    assign icu_rst   = r_icu_rst;
    assign halted    = (r_state == HALT);
    assign stack_err = r_stack_err;

endmodule
`default_nettype wire

// File: tb/tb_mc14500_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_mc14500_sequencer
// Brief    : Directed bench with a behavioural ICU flag decoder and ROM model.
// Revision : 1.0
// ============================================================================
module tb_mc14500_sequencer;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [7:0]  rom_addr;
    logic [11:0] rom_data;
    logic [3:0]  opcode;
    logic        icu_jmp;
    logic        icu_rtn;
    logic        icu_flag_f;
    logic        icu_rst;
    logic        resume = 1'b0;
    logic        halted;
    logic        stack_err;

    logic [11:0] rom [256];
    logic [3:0]  icu_ir = 4'h0;

    int tests  = 0;
    int errors = 0;

    always #5 clk = ~clk;

    assign rom_data   = rom[rom_addr];
    always @(negedge clk) icu_ir <= opcode;
    assign icu_jmp    = (icu_ir == 4'hC);
    assign icu_rtn    = (icu_ir == 4'hD);
    assign icu_flag_f = (icu_ir == 4'hF);

    mc14500_sequencer #(
        .ADDR_W      (8),
        .STACK_DEPTH (4)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .rom_addr   (rom_addr),
        .rom_data   (rom_data),
        .opcode     (opcode),
        .icu_jmp    (icu_jmp),
        .icu_rtn    (icu_rtn),
        .icu_flag_f (icu_flag_f),
        .icu_rst    (icu_rst),
        .resume     (resume),
        .halted     (halted),
        .stack_err  (stack_err)
    );

    typedef struct {
        logic       rst;
        logic [7:0] addr;
        logic [3:0] opc;
        logic       icu_rst;
        logic       halted;
        logic       err;
    } vec_t;

    vec_t vecs [15];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic fill_rom();
        for (int i = 0; i < 256; i++) rom[i] = {4'h1, 8'h00};
    endtask

    task automatic enter_reset();
        rst = 1'b0;
        tick();
    endtask

    task automatic release_reset();
        tick();
        rst = 1'b1;
        tick();
        tick();
    endtask

    logic [7:0] ovf_pc  [10] = '{8'h10, 8'h20, 8'h30, 8'h40, 8'h50,
                                 8'h31, 8'h21, 8'h11, 8'h01, 8'h02};
    logic       ovf_err [10] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1,
                                 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};

    initial begin
        // Reset release followed by a jump/return pair
        fill_rom();
        rom[8'h05] = {4'hC, 8'h40};
        rom[8'h40] = {4'h5, 8'h00};
        rom[8'h41] = {4'h5, 8'h00};
        rom[8'h42] = {4'hD, 8'h00};

        vecs[0]  = '{1'b0, 8'h00, 4'h0, 1'b1, 1'b0, 1'b0};
        vecs[1]  = '{1'b0, 8'h00, 4'h0, 1'b1, 1'b0, 1'b0};
        vecs[2]  = '{1'b0, 8'h00, 4'h0, 1'b1, 1'b0, 1'b0};
        vecs[3]  = '{1'b1, 8'h00, 4'h0, 1'b1, 1'b0, 1'b0};
        vecs[4]  = '{1'b1, 8'h00, 4'h1, 1'b0, 1'b0, 1'b0};
        vecs[5]  = '{1'b1, 8'h01, 4'h1, 1'b0, 1'b0, 1'b0};
        vecs[6]  = '{1'b1, 8'h02, 4'h1, 1'b0, 1'b0, 1'b0};
        vecs[7]  = '{1'b1, 8'h03, 4'h1, 1'b0, 1'b0, 1'b0};
        vecs[8]  = '{1'b1, 8'h04, 4'h1, 1'b0, 1'b0, 1'b0};
        vecs[9]  = '{1'b1, 8'h05, 4'hC, 1'b0, 1'b0, 1'b0};
        vecs[10] = '{1'b1, 8'h40, 4'h5, 1'b0, 1'b0, 1'b0};
        vecs[11] = '{1'b1, 8'h41, 4'h5, 1'b0, 1'b0, 1'b0};
        vecs[12] = '{1'b1, 8'h42, 4'hD, 1'b0, 1'b0, 1'b0};
        vecs[13] = '{1'b1, 8'h06, 4'h1, 1'b0, 1'b0, 1'b0};
        vecs[14] = '{1'b1, 8'h07, 4'h1, 1'b0, 1'b0, 1'b0};

        for (int i = 0; i < 15; i++) begin
            rst = vecs[i].rst;
            tick();
            check($sformatf("vec%0d {addr,opc,icu_rst,halted,err}", i),
                  {17'd0, rom_addr, opcode, icu_rst, halted, stack_err},
                  {17'd0, vecs[i].addr, vecs[i].opc, vecs[i].icu_rst,
                   vecs[i].halted, vecs[i].err});
        end

        // Overflow: five nested jumps, then four LIFO returns
        enter_reset();
        fill_rom();
        rom[8'h00] = {4'hC, 8'h10};
        rom[8'h10] = {4'hC, 8'h20};
        rom[8'h20] = {4'hC, 8'h30};
        rom[8'h30] = {4'hC, 8'h40};
        rom[8'h40] = {4'hC, 8'h50};
        rom[8'h50] = {4'hD, 8'h00};
        rom[8'h31] = {4'hD, 8'h00};
        rom[8'h21] = {4'hD, 8'h00};
        rom[8'h11] = {4'hD, 8'h00};
        release_reset();
        check("ovf_start_pc", {24'd0, rom_addr}, 32'h00);
        for (int i = 0; i < 10; i++) begin
            tick();
            check($sformatf("ovf_step%0d {pc,err}", i),
                  {23'd0, rom_addr, stack_err}, {23'd0, ovf_pc[i], ovf_err[i]});
        end

        // Underflow: return with an empty stack
        enter_reset();
        fill_rom();
        rom[8'h03] = {4'hD, 8'h00};
        release_reset();
        for (int i = 1; i <= 5; i++) begin
            tick();
            check($sformatf("udf_pc%0d {pc,err}", i),
                  {23'd0, rom_addr, stack_err},
                  {23'd0, 8'(i), (i >= 4) ? 1'b1 : 1'b0});
        end

        // Halt and resume
        enter_reset();
        fill_rom();
        rom[8'h10] = {4'hF, 8'h00};
        rom[8'h11] = {4'h8, 8'h00};
        release_reset();
        repeat (16) tick();
        check("halt_pre {pc,halted,opc}", {19'd0, rom_addr, halted, opcode},
              {19'd0, 8'h10, 1'b0, 4'hF});
        tick();
        check("halt_entry {pc,halted,opc}", {19'd0, rom_addr, halted, opcode},
              {19'd0, 8'h11, 1'b1, 4'h0});
        for (int i = 0; i < 10; i++) begin
            tick();
            check($sformatf("halt_hold%0d {pc,halted,opc}", i),
                  {19'd0, rom_addr, halted, opcode}, {19'd0, 8'h11, 1'b1, 4'h0});
        end
        resume = 1'b1;
        tick();
        resume = 1'b0;
        check("resume {pc,halted,opc}", {19'd0, rom_addr, halted, opcode},
              {19'd0, 8'h11, 1'b0, 4'h8});
        tick();
        check("resume_next_pc", {24'd0, rom_addr}, 32'h12);

        // PC wrap
        enter_reset();
        fill_rom();
        release_reset();
        repeat (255) tick();
        check("wrap_ff", {24'd0, rom_addr}, 32'hFF);
        tick();
        check("wrap_00", {24'd0, rom_addr}, 32'h00);

        // Mid-run reset while halted with two stack entries and a sticky error
        enter_reset();
        fill_rom();
        rom[8'h00] = {4'hD, 8'h00};
        rom[8'h01] = {4'hC, 8'h80};
        rom[8'h80] = {4'hC, 8'h90};
        rom[8'h90] = {4'hF, 8'h00};
        release_reset();
        repeat (4) tick();
        check("mid_pre {pc,halted,err}", {22'd0, rom_addr, halted, stack_err},
              {22'd0, 8'h91, 1'b1, 1'b1});
        rst = 1'b0;
        tick();
        check("mid_rst {pc,opc,icu_rst,halted,err}",
              {17'd0, rom_addr, opcode, icu_rst, halted, stack_err},
              {17'd0, 8'h00, 4'h0, 1'b1, 1'b0, 1'b0});
        rst = 1'b1;
        tick();
        tick();
        check("mid_restart {pc,opc,err}", {19'd0, rom_addr, opcode, stack_err},
              {19'd0, 8'h00, 4'hD, 1'b0});
        tick();
        check("mid_sp_empty {pc,err}", {23'd0, rom_addr, stack_err}, {23'd0, 8'h01, 1'b1});

        $display("[TB] %0d tests run, %0d failed", tests, errors);
        $finish;
    end

endmodule
`default_nettype wire
